// File: rtl/bcd_seg7_scan_if.sv
// Signal bundle between the bcd converter side and the 3-digit scan driver.
// The master drives the digits and controls; the slave drives the display pins.
interface bcd_seg7_scan_if;
    logic       load;
    logic [3:0] hundreds_digit;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;

    modport master (
        output load, hundreds_digit, tens_digit, ones_digit, blank_lz,
        input  seg, an, frame
    );

    modport slave (
        input  load, hundreds_digit, tens_digit, ones_digit, blank_lz,
        output seg, an, frame
    );
endinterface

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 3-digit seven-segment driver with leading-zero blanking.
// state | meaning
// OFF   | after reset, display dark until the first slot tick
// D0    | ones digit slot,     an = 110
// D1    | tens digit slot,     an = 101
// D2    | hundreds digit slot, an = 011 (frame pulses on entry)
module bcd_seg7_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_seg7_scan_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {OFF, D0, D1, D2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    h_q, t_q, o_q;
    logic [3:0]    digit_sel;
    logic          blank_sel;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          frame_q, frame_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            t_q <= '0;
            o_q <= '0;
        end else if (bus.load) begin
            h_q <= bus.hundreds_digit;
            t_q <= bus.tens_digit;
            o_q <= bus.ones_digit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            seg_q   <= '0;
            an_q    <= 3'b111;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            if (tick) begin
                seg_q <= seg_d;
                an_q  <= an_d;
            end
        end
    end

    // Outputs are computed for the destination slot using the pre-edge latch values.
    always_comb begin
        state_d   = state_q;
        digit_sel = o_q;
        blank_sel = 1'b0;
        an_d      = 3'b111;
        if (tick) begin
            case (state_q)
                D0:      state_d = D1;
                D1:      state_d = D2;
                default: state_d = D0;
            endcase
        end
        case (state_d)
            D0: begin
                an_d      = 3'b110;
                digit_sel = o_q;
            end
            D1: begin
                an_d      = 3'b101;
                digit_sel = t_q;
                blank_sel = bus.blank_lz && (h_q == 4'd0) && (t_q == 4'd0);
            end
            D2: begin
                an_d      = 3'b011;
                digit_sel = h_q;
                blank_sel = bus.blank_lz && (h_q == 4'd0);
            end
            default: begin
                an_d      = 3'b111;
                blank_sel = 1'b1;
            end
        endcase
        seg_d   = blank_sel ? 7'h00 : decode(digit_sel);
        frame_d = tick && (state_q == D1);
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed bench for bcd_seg7_scan at REFRESH_DIV=4; k counts rising edges since
// reset release and outputs are sampled on the falling edge after edge k.
module tb_bcd_seg7_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   k = 0;

    bcd_seg7_scan_if bus ();

    bcd_seg7_scan #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic restart(input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o, input logic blz);
        @(negedge clk);
        rst_n = 1'b0;
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.load = 1'b1;
        bus.hundreds_digit = h;
        bus.tens_digit = t;
        bus.ones_digit = o;
        bus.blank_lz = blz;
        k = 0;
        @(negedge clk);
        k = 1;
        bus.load = 1'b0;
    endtask

    task automatic wait_to(input int n);
        while (k < n) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        restart(4'd1, 4'd1, 4'd1, 1'b0);
        vectors++;
        if (bus.seg !== 7'h00 || bus.an !== 3'b111 || bus.frame !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: seg=%h an=%b frame=%b required seg=00 an=111 frame=0",
                     bus.seg, bus.an, bus.frame);
        end
        wait_to(12);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.seg !== 7'h00 || bus.an !== 3'b111 || bus.frame !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: seg=%h an=%b frame=%b required seg=00 an=111 frame=0",
                     bus.seg, bus.an, bus.frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.an !== ((i < 4) ? 3'b111 : 3'b110)) begin
                miscompares++;
                $display("FAIL startup_an[%0d]: an=%b required %b", i, bus.an,
                         (i < 4) ? 3'b111 : 3'b110);
            end
        end
    endtask

    task automatic test_full_scan();
        logic [6:0] seg_tab[3];
        logic [2:0] an_tab[3];
        logic [6:0] seg_exp;
        logic [2:0] an_exp;
        logic       frame_exp;
        seg_tab = '{7'h6D, 7'h6D, 7'h5B};
        an_tab  = '{3'b110, 3'b101, 3'b011};
        restart(4'd2, 4'd5, 4'd5, 1'b0);
        for (int i = 1; i <= 28; i++) begin
            wait_to(i);
            if (i < 4) begin
                seg_exp = 7'h00;
                an_exp  = 3'b111;
            end else begin
                seg_exp = seg_tab[((i - 4) / 4) % 3];
                an_exp  = an_tab[((i - 4) / 4) % 3];
            end
            frame_exp = (i == 12) || (i == 24);
            vectors++;
            if (bus.seg !== seg_exp || bus.an !== an_exp || bus.frame !== frame_exp) begin
                miscompares++;
                $display("FAIL full_scan[k=%0d]: seg=%h an=%b frame=%b required seg=%h an=%b frame=%b",
                         i, bus.seg, bus.an, bus.frame, seg_exp, an_exp, frame_exp);
            end
        end
    endtask

    task automatic test_blanking();
        restart(4'd0, 4'd0, 4'd7, 1'b1);
        wait_to(4);
        vectors++;
        if (bus.seg !== 7'h07) begin
            miscompares++;
            $display("FAIL blank_007_ones: seg=%h required 07", bus.seg);
        end
        wait_to(8);
        vectors++;
        if (bus.seg !== 7'h00 || bus.an !== 3'b101) begin
            miscompares++;
            $display("FAIL blank_007_tens: seg=%h an=%b required seg=00 an=101", bus.seg, bus.an);
        end
        wait_to(12);
        vectors++;
        if (bus.seg !== 7'h00 || bus.an !== 3'b011) begin
            miscompares++;
            $display("FAIL blank_007_hund: seg=%h an=%b required seg=00 an=011", bus.seg, bus.an);
        end
        restart(4'd0, 4'd4, 4'd0, 1'b1);
        wait_to(4);
        vectors++;
        if (bus.seg !== 7'h3F) begin
            miscompares++;
            $display("FAIL blank_040_ones: seg=%h required 3F", bus.seg);
        end
        wait_to(8);
        vectors++;
        if (bus.seg !== 7'h66) begin
            miscompares++;
            $display("FAIL blank_040_tens: seg=%h required 66", bus.seg);
        end
        wait_to(12);
        vectors++;
        if (bus.seg !== 7'h00) begin
            miscompares++;
            $display("FAIL blank_040_hund: seg=%h required 00", bus.seg);
        end
    endtask

    task automatic test_out_of_range();
        restart(4'd12, 4'd0, 4'd9, 1'b1);
        wait_to(4);
        vectors++;
        if (bus.seg !== 7'h6F) begin
            miscompares++;
            $display("FAIL oor_ones: seg=%h required 6F", bus.seg);
        end
        wait_to(8);
        vectors++;
        if (bus.seg !== 7'h3F) begin
            miscompares++;
            $display("FAIL oor_tens: seg=%h required 3F", bus.seg);
        end
        wait_to(12);
        vectors++;
        if (bus.seg !== 7'h40) begin
            miscompares++;
            $display("FAIL oor_hund: seg=%h required 40", bus.seg);
        end
    endtask

    task automatic test_load_on_tick();
        restart(4'd1, 4'd2, 4'd3, 1'b0);
        wait_to(4);
        vectors++;
        if (bus.seg !== 7'h4F) begin
            miscompares++;
            $display("FAIL lot_ones_old: seg=%h required 4F", bus.seg);
        end
        wait_to(7);
        bus.load = 1'b1;
        bus.hundreds_digit = 4'd9;
        bus.tens_digit = 4'd8;
        bus.ones_digit = 4'd7;
        wait_to(8);
        bus.load = 1'b0;
        vectors++;
        if (bus.seg !== 7'h5B || bus.an !== 3'b101) begin
            miscompares++;
            $display("FAIL lot_tens_old: seg=%h an=%b required seg=5B an=101", bus.seg, bus.an);
        end
        wait_to(12);
        vectors++;
        if (bus.seg !== 7'h6F || bus.an !== 3'b011) begin
            miscompares++;
            $display("FAIL lot_hund_new: seg=%h an=%b required seg=6F an=011", bus.seg, bus.an);
        end
        wait_to(16);
        vectors++;
        if (bus.seg !== 7'h07) begin
            miscompares++;
            $display("FAIL lot_ones_new: seg=%h required 07", bus.seg);
        end
    endtask

    task automatic test_blank_toggle();
        restart(4'd0, 4'd0, 4'd5, 1'b0);
        wait_to(9);
        bus.blank_lz = 1'b1;
        wait_to(11);
        vectors++;
        if (bus.seg !== 7'h3F) begin
            miscompares++;
            $display("FAIL toggle_hold: seg=%h required 3F", bus.seg);
        end
        wait_to(12);
        vectors++;
        if (bus.seg !== 7'h00) begin
            miscompares++;
            $display("FAIL toggle_apply: seg=%h required 00", bus.seg);
        end
    endtask

    task automatic test_prescaler_count();
        int         an_changes;
        int         frames;
        int         bad_an;
        logic [2:0] an_prev;
        an_changes = 0;
        frames = 0;
        bad_an = 0;
        restart(4'd3, 4'd2, 4'd1, 1'b0);
        an_prev = 3'b111;
        for (int i = 1; i <= 120; i++) begin
            wait_to(i);
            if (bus.an !== an_prev) an_changes++;
            if (bus.frame === 1'b1) frames++;
            if (i >= 4 && bus.an !== 3'b110 && bus.an !== 3'b101 && bus.an !== 3'b011) bad_an++;
            an_prev = bus.an;
        end
        vectors++;
        if (an_changes != 30) begin
            miscompares++;
            $display("FAIL tick_count: observed %0d required 30", an_changes);
        end
        vectors++;
        if (frames != 10) begin
            miscompares++;
            $display("FAIL frame_count: observed %0d required 10", frames);
        end
        vectors++;
        if (bad_an != 0) begin
            miscompares++;
            $display("FAIL an_onehot: %0d bad cycles required 0", bad_an);
        end
    endtask

    initial begin
        bus.load = 1'b0;
        bus.hundreds_digit = 4'd0;
        bus.tens_digit = 4'd0;
        bus.ones_digit = 4'd0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_full_scan();
        test_blanking();
        test_out_of_range();
        test_load_on_tick();
        test_blank_toggle();
        test_prescaler_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
